pc_fetch_seq: RTL
=================

Name: pc_fetch_seq

Overview:
Program-counter and fetch sequencer. It is the consumer and producer around the next-address select mux.
- Holds the current PC and issues instruction-fetch requests to instruction memory with a req/ack handshake.
- After each fetch, loads the next PC from either PC+STEP or the jump direction, as chosen by sel_dir.
- Sits between the decode/branch logic (source of direction, sel_dir, stall) and the instruction memory port.

Parameters:
WIDTH, 32, address and instruction width in bits
RESET_ADDR, 32'h00000000, PC value loaded on reset
STEP, 1, PC increment for a sequential fetch (word addressing)
TIMEOUT, 15, max cycles to wait for mem_ack before flagging an error and retrying (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
direction  in  WIDTH  jump/branch target address
sel_dir  in  1  1 = next PC is direction; 0 = next PC is pc+STEP
stall  in  1  1 = hold in UPDATE; PC does not advance
mem_ack  in  1  instruction memory: mem_rdata valid this cycle
mem_rdata  in  WIDTH  instruction word from memory
mem_req  out  1  fetch request, held high until ack or timeout
mem_addr  out  WIDTH  fetch address, equals pc while mem_req=1
pc  out  WIDTH  current program counter
instr  out  WIDTH  last fetched instruction word
instr_valid  out  1  instr holds the word fetched from pc (high in UPDATE)
fetch_err  out  1  sticky: a fetch timed out at least once since reset

Behaviour:
- Reset (async, immediate, also mid-transaction):
  - pc=RESET_ADDR, mem_addr=RESET_ADDR, instr=0, mem_req=0, instr_valid=0, fetch_err=0.
  - Timeout counter=0, state=BOOT.
- FSM states:
  - BOOT: one cycle after reset release, all outputs at reset values. Next state is FETCH.
  - FETCH: mem_req=1, mem_addr=pc. Counter increments each cycle.
    - mem_ack=1: instr<=mem_rdata, instr_valid<=1, mem_req<=0, counter<=0, next state UPDATE.
    - Counter reaches TIMEOUT with no ack: fetch_err<=1, mem_req<=0, counter<=0, next state RETRY.
  - RETRY: one cycle with mem_req=0, then back to FETCH with the same pc.
  - UPDATE: instr_valid=1.
    - stall=1: stay; pc and instr held.
    - stall=0: pc<=(sel_dir ? direction : pc+STEP), instr_valid<=0, next state FETCH.
- Registered outputs: mem_req, mem_addr and instr_valid change only on clock edges.
- Minimum loop with zero-wait memory: FETCH (ack same cycle) -> UPDATE -> FETCH, i.e. 2 cycles per instruction.
- mem_ack outside FETCH is ignored; instr is not updated.
- sel_dir and direction are sampled only on the UPDATE edge with stall=0. Values at any other time have no effect.
- Arithmetic: pc+STEP is modulo 2^WIDTH; 32'hFFFFFFFF + 1 wraps to 0, with no flag.
- Simultaneous events:
  - mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
  - stall=1 together with sel_dir=1 in UPDATE: stall wins; the jump is taken on the first UPDATE cycle with stall=0, using the direction/sel_dir present then.
- fetch_err is cleared only by reset.

Test Plan:
- Reset/boot: reset high 100 ns, release -> pc=0, mem_req=0 during BOOT, mem_req=1 with mem_addr=0 the next cycle.
- Sequential fetch, zero-wait memory (mem_ack=1 whenever mem_req=1, mem_rdata=32'h1000_0000+addr), sel_dir=0 -> pc goes 0,1,2,3 every 2 cycles; instr=32'h10000000,...,32'h10000003.
- Jump: direction=32'hAAAAAAAA, sel_dir=1 during an UPDATE with pc=5 -> next mem_addr=32'hAAAAAAAA; then sel_dir=0 -> 32'hAAAAAAAB.
- Wrap and stall: jump to 32'hFFFFFFFF, hold stall=1 for 3 cycles in UPDATE -> pc stays 32'hFFFFFFFF, instr_valid stays 1; release stall -> pc=0.
- Timeout: mem_ack=0 for 20 cycles -> mem_req drops after 15 cycles of FETCH, fetch_err=1, mem_req high again 1 cycle later at the same address; ack then -> normal flow, fetch_err stays 1.
- Reset mid-fetch: assert reset while mem_req=1 and pc=32'h00000007 -> mem_req, pc, instr_valid, fetch_err go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_seq_if.sv
// Instruction-memory fetch port: request/address out, acknowledge/read data back.
interface pc_fetch_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program counter and fetch sequencer: fetches the word at pc, then advances pc
// to pc+STEP or to a jump target, with bounded wait and retry on missing acks.
module pc_fetch_seq #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      STEP       = 1,
  parameter int unsigned      TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  direction,
  input  logic              sel_dir,
  input  logic              stall,
  pc_fetch_seq_if.master    mem,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  instr,
  output logic              instr_valid,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    RETRY  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Counter value seen during the last permitted FETCH cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] instr_d;
  logic             err_d;

  // Wraps modulo 2^WIDTH by construction; no overflow indication.
  function automatic logic [WIDTH-1:0] next_pc(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] dir,
    input logic             jump
  );
    return jump ? dir : (cur + WIDTH'(STEP));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc;
    instr_d = instr;
    err_d   = fetch_err;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        // An ack arriving on the final wait cycle still completes the fetch.
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          cnt_d   = '0;
          state_d = UPDATE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RETRY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RETRY: begin
        state_d = FETCH;
      end
      UPDATE: begin
        if (!stall) begin
          pc_d    = next_pc(pc, direction, sel_dir);
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Outputs are registered from the next state so they only move on clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      cnt_q        <= '0;
      pc           <= RESET_ADDR;
      instr        <= '0;
      fetch_err    <= 1'b0;
      instr_valid  <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc           <= pc_d;
      instr        <= instr_d;
      fetch_err    <= err_d;
      instr_valid  <= (state_d == UPDATE);
      mem.mem_req  <= (state_d == FETCH);
      mem.mem_addr <= pc_d;
    end
  end

endmodule
